// File: rtl/sha256_pkg.sv
// SHA-256 constants, round/schedule helper functions and shared types.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  // Working variables a..h; a occupies the top word when packed.
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } hstate_t;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_if.sv
// Start/block/chain request and busy/complete/digest response of the SHA-256 core.
// The abort input exists only when SHA256_ABORT_EN is defined.
interface sha256_if;
  logic         start;
  logic [511:0] block;
  logic [255:0] chain_in;
  logic         busy;
  logic         complete;
  logic [255:0] digest;
`ifdef SHA256_ABORT_EN
  logic         abort;

  modport master (output start, block, chain_in, abort, input busy, complete, digest);
  modport slave  (input start, block, chain_in, abort, output busy, complete, digest);
`else
  modport master (output start, block, chain_in, input busy, complete, digest);
  modport slave  (input start, block, chain_in, output busy, complete, digest);
`endif
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
  import sha256_pkg::*;
(
  input  hstate_t     s_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output hstate_t     s_o
);
  logic [31:0] t1, t2;

  assign t1 = s_i.h + Sigma1(s_i.e) + ch(s_i.e, s_i.f, s_i.g) + k_i + w_i;
  assign t2 = Sigma0(s_i.a) + maj(s_i.a, s_i.b, s_i.c);

  assign s_o = '{a: t1 + t2, b: s_i.a, c: s_i.b, d: s_i.c,
                 e: s_i.d + t1, f: s_i.e, g: s_i.f, h: s_i.g};
endmodule

// File: rtl/sha256_core.sv
// SHA-256 compression engine: UNROLL rounds per clock over one 512-bit block.
// Define SHA256_ABORT_EN to add the abort input.
module sha256_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic      clk,
  input logic      rst,
  sha256_if.slave  bus
);
  localparam int         N_ROUND_CYC = 64 / UNROLL;
  localparam logic [5:0] LAST_RND    = 6'((N_ROUND_CYC - 1) * UNROLL);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha256_core: UNROLL must be 1, 2 or 4");
  end

  state_e             state_q;
  logic               busy_q, complete_q;
  logic [255:0]       digest_q, digest_d;
  hstate_t            hs_q, hs_d, hold_q;
  logic [0:15][31:0]  w_q, w_d;
  logic [5:0]         rnd_q;
  logic [31:0]        wn_all [UNROLL];

  // w_q[0] is W[rnd]; each cycle consumes UNROLL words and appends UNROLL new ones.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [31:0] w2, wn;
    hstate_t     si, so;

    if (j < 2) begin : g_w2
      assign w2 = w_q[14+j];
    end else begin : g_w2
      assign w2 = g_rnd[j-2].wn;
    end

    if (j == 0) begin : g_si
      assign si = hs_q;
    end else begin : g_si
      assign si = g_rnd[j-1].so;
    end

    assign wn        = sigma1(w2) + w_q[9+j] + sigma0(w_q[1+j]) + w_q[j];
    assign wn_all[j] = wn;

    sha256_round u_round (
      .s_i (si),
      .k_i (K[rnd_q + 6'(j)]),
      .w_i (w_q[j]),
      .s_o (so)
    );
  end

  for (genvar i = 0; i < 16; i++) begin : g_wshift
    if (i < 16 - UNROLL) begin : g_old
      assign w_d[i] = w_q[i+UNROLL];
    end else begin : g_new
      assign w_d[i] = wn_all[i-16+UNROLL];
    end
  end

  assign hs_d     = g_rnd[UNROLL-1].so;
  assign digest_d = {hs_q.a + hold_q.a, hs_q.b + hold_q.b, hs_q.c + hold_q.c, hs_q.d + hold_q.d,
                     hs_q.e + hold_q.e, hs_q.f + hold_q.f, hs_q.g + hold_q.g, hs_q.h + hold_q.h};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      digest_q   <= '0;
      hs_q       <= '0;
      hold_q     <= '0;
      w_q        <= '0;
      rnd_q      <= '0;
    end else begin
      complete_q <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.start) begin
          w_q     <= bus.block;
          hs_q    <= hstate_t'(bus.chain_in);
          hold_q  <= hstate_t'(bus.chain_in);
          rnd_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= ROUND;
        end
        ROUND: begin
          hs_q  <= hs_d;
          w_q   <= w_d;
          rnd_q <= rnd_q + 6'(UNROLL);
          if (rnd_q == LAST_RND) state_q <= FINAL;
        end
        FINAL: begin
          digest_q   <= digest_d;
          complete_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
`ifdef SHA256_ABORT_EN
      // Abort overrides the ROUND/FINAL updates; digest_q keeps its prior value.
      if (bus.abort && (state_q == ROUND || state_q == FINAL)) begin
        state_q    <= IDLE;
        busy_q     <= 1'b0;
        complete_q <= 1'b0;
        digest_q   <= digest_q;
      end
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.complete = complete_q;
  assign bus.digest   = digest_q;
endmodule

// File: tb/tb_sha256_core.sv
// Scoreboard bench for sha256_core: UNROLL=1 main instance plus UNROLL=2/4 latency instances.
module tb_sha256_core;
  localparam int LAT = 66;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] MID_BLK   = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] IV_T      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DG    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DG  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [255:0] dg;
    int           cy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t0 = 0;
  int   c2 = -1, c4 = -1;
  logic [255:0] d2, d4;
  exp_t sb [$];
  exp_t m_e;

  sha256_if if1 ();
  sha256_if if2 ();
  sha256_if if4 ();

  assign if2.start = if1.start;   assign if4.start = if1.start;
  assign if2.block = if1.block;   assign if4.block = if1.block;
  assign if2.chain_in = if1.chain_in;
  assign if4.chain_in = if1.chain_in;
`ifdef SHA256_ABORT_EN
  assign if2.abort = if1.abort;   assign if4.abort = if1.abort;
`endif

  sha256_core #(.UNROLL(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sha256_core #(.UNROLL(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  sha256_core #(.UNROLL(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight FIPS 180-4 compression with a full 64-entry schedule.
  function automatic logic [255:0] sha_ref(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) h[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    v = h;
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[i] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rnd_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] rnd_chain();
    logic [255:0] c;
    for (int i = 0; i < 8; i++) c[32*i +: 32] = $urandom;
    return c;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle from a negedge; returns at the next negedge.
  task automatic job(input logic [511:0] b, input logic [255:0] c, input logic [255:0] e, input bit push);
    if1.start = 1'b1; if1.block = b; if1.chain_in = c;
    t0 = cyc;
    if (push) sb.push_back('{dg: e, cy: t0 + LAT});
    @(negedge clk);
    if1.start = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 256'(sb.size()), 256'(0));
  endtask

  always @(negedge clk) begin
    if (if1.complete) begin
      if (sb.size() == 0) check("spurious_complete", 256'(1), 256'(0));
      else begin
        m_e = sb.pop_front();
        check("digest", if1.digest, m_e.dg);
        check("latency", 256'(cyc), 256'(m_e.cy));
      end
    end
    if (if2.complete && c2 < 0) begin c2 = cyc; d2 = if2.digest; end
    if (if4.complete && c4 < 0) begin c4 = cyc; d4 = if4.digest; end
  end

  initial begin
    int bad;
    logic [511:0] rb1, rb2, rb;
    logic [255:0] rc1, rc2, rc, prev;
    if1.start = 1'b0; if1.block = '0; if1.chain_in = '0;
`ifdef SHA256_ABORT_EN
    if1.abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", 256'(if1.busy), 256'(0));
    check("rst_complete", 256'(if1.complete), 256'(0));
    check("rst_digest", if1.digest, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Empty message on all three unroll factors.
    job(EMPTY_BLK, IV_T, EMPTY_DG, 1'b1);
    drain(100);
    check("u2_latency", 256'(c2), 256'(t0 + 34));
    check("u2_digest", d2, EMPTY_DG);
    check("u4_latency", 256'(c4), 256'(t0 + 18));
    check("u4_digest", d4, EMPTY_DG);

    // "abc" with start re-pulsed mid-job; busy high exactly cycles 1..66.
    check("idle_busy", 256'(if1.busy), 256'(0));
    job(ABC_BLK, IV_T, ABC_DG, 1'b1);
    bad = 0;
    for (int k = 1; k <= 67; k++) begin
      if (if1.busy !== (k <= 66)) bad++;
      if1.start = (k == 10 || k == 40);
      @(negedge clk);
    end
    if1.start = 1'b0;
    check("busy_window", 256'(bad), 256'(0));
    drain(10);

    // Digest holds the previous result until the next job's FINAL.
    bad = (if1.digest !== ABC_DG) ? 1 : 0;
    job(EMPTY_BLK, IV_T, EMPTY_DG, 1'b1);
    for (int k = 1; k < 66; k++) begin
      if (if1.digest !== ABC_DG) bad++;
      @(negedge clk);
    end
    check("digest_hold", 256'(bad), 256'(0));
    drain(10);

    // Midstate chaining into a second block.
    job(MID_BLK, ABC_DG, sha_ref(ABC_DG, MID_BLK), 1'b1);
    drain(100);

    // start held high: back-to-back jobs, one idle cycle apart; inputs change between accepts.
    rb1 = rnd_blk(); rc1 = rnd_chain(); rb2 = rnd_blk(); rc2 = rnd_chain();
    if1.start = 1'b1; if1.block = rb1; if1.chain_in = rc1;
    t0 = cyc;
    sb.push_back('{dg: sha_ref(rc1, rb1), cy: t0 + LAT});
    sb.push_back('{dg: sha_ref(rc2, rb2), cy: t0 + 2*LAT + 1});
    repeat (3) @(negedge clk);
    if1.block = rb2; if1.chain_in = rc2;
    repeat (67) @(negedge clk);
    if1.start = 1'b0;
    drain(100);

    // Asynchronous reset mid-job.
    job(ABC_BLK, IV_T, ABC_DG, 1'b1);
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 256'(if1.busy), 256'(0));
    check("midrst_complete", 256'(if1.complete), 256'(0));
    check("midrst_digest", if1.digest, 256'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    job(ABC_BLK, IV_T, ABC_DG, 1'b1);
    drain(100);

    for (int n = 0; n < 3; n++) begin
      rb = rnd_blk(); rc = rnd_chain();
      job(rb, rc, sha_ref(rc, rb), 1'b1);
      drain(100);
    end

`ifdef SHA256_ABORT_EN
    prev = if1.digest;
    job(ABC_BLK, IV_T, ABC_DG, 1'b0);
    repeat (19) @(negedge clk);
    check("abort_busy_before", 256'(if1.busy), 256'(1));
    if1.abort = 1'b1;
    @(negedge clk);
    if1.abort = 1'b0;
    check("abort_busy_fall", 256'(if1.busy), 256'(0));
    repeat (70) @(negedge clk);
    check("abort_digest_kept", if1.digest, prev);
    job(EMPTY_BLK, IV_T, EMPTY_DG, 1'b1);
    drain(100);
`else
    prev = '0;
    rc = prev;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
